lc3_memory: RTL and testbench

LC3_MEMORY -- requirements
Module: lc3_memory

---
 rtl/lc3_pkg.sv | 21 ++
 rtl/lc3_ram.sv | 24 ++
 rtl/lc3_memory.sv | 167 ++++++++++++++++
 tb/tb_lc3_memory.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory responder: device register addresses
// and the responder state encoding.
package lc3_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lc3_state_t;

    function automatic logic is_device(input logic [15:0] addr);
        return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_ram.sv
// Single-port word RAM: synchronous write, combinational read, no reset so
// contents survive a system reset.
module lc3_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [15:0] mem_r [2**ADDR_BITS];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/lc3_memory.sv
// LC-3 memory responder: wait-stated RAM access plus memory-mapped keyboard
// and display registers, handshaking with the control FSM via mio_en / r.
module lc3_memory
    import lc3_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_BITS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic        r,
    output logic [15:0] mdr_out,
    input  logic        kb_valid,
    input  logic [15:0] kb_data,
    output logic        kb_ready,
    output logic        ddr_valid,
    output logic [15:0] ddr_data,
    input  logic        ddr_ready
);

    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    lc3_state_t  state_r, state_nx_s;
    logic [3:0]  count_r, count_nx_s;
    logic        latch_s, access_s;
    logic        rw_r;
    logic [15:0] addr_r, wdata_r;
    logic        kbsr_r, dsr_r;
    logic [15:0] kbdr_r;
    logic        ram_we_s, kb_accept_s, kbdr_clear_s, ddr_load_s, ddr_xfer_s;
    logic [15:0] ram_rdata_s, rd_data_s;

    lc3_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (addr_r[ADDR_BITS-1:0]),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            count_r <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            count_r <= count_nx_s;
        end
    end

    // Next-state logic; dropping mio_en before the access edge aborts it.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        latch_s    = 1'b0;
        access_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mio_en) begin
                    latch_s = 1'b1;
                    if (WS_L == 4'd0) begin
                        state_nx_s = DONE;
                        count_nx_s = 4'd0;
                    end else begin
                        state_nx_s = WAIT;
                        count_nx_s = WS_L;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (!mio_en) begin
                    state_nx_s = IDLE;
                    count_nx_s = 4'd0;
                end else if (count_r <= 4'd1) begin
                    state_nx_s = DONE;
                    count_nx_s = 4'd0;
                end else begin
                    state_nx_s = WAIT;
                    count_nx_s = count_r - 4'd1;
                end
            end
            DONE: begin
                access_s   = mio_en;
                state_nx_s = IDLE;
                count_nx_s = 4'd0;
            end
            default: begin
                state_nx_s = IDLE;
                count_nx_s = 4'd0;
            end
        endcase
    end

    // Access decode and read-data select.
    always_comb begin
        ram_we_s     = access_s && rw_r && !is_device(addr_r);
        kbdr_clear_s = access_s && !rw_r && (addr_r == KBDR_ADDR);
        ddr_load_s   = access_s && rw_r && (addr_r == DDR_ADDR) && dsr_r;
        kb_accept_s  = kb_valid && !kbsr_r;
        ddr_xfer_s   = ddr_valid && ddr_ready;
        case (addr_r)
            KBSR_ADDR: rd_data_s = {kbsr_r, 15'd0};
            KBDR_ADDR: rd_data_s = kbdr_r;
            DSR_ADDR:  rd_data_s = {dsr_r, 15'd0};
            DDR_ADDR:  rd_data_s = 16'h0000;
            default:   rd_data_s = ram_rdata_s;
        endcase
    end

    // Request latch, ready pulse and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_r    <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
            r       <= 1'b0;
            mdr_out <= 16'h0000;
        end else begin
            if (latch_s) begin
                rw_r    <= r_w;
                addr_r  <= mar;
                wdata_r <= mdr_in;
            end
            r <= access_s;
            if (access_s && !rw_r) begin
                mdr_out <= rd_data_s;
            end
        end
    end

    // Keyboard and display registers; kb_ready low while a character is held
    // keeps a KBDR-read clear and a new accept from ever colliding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbsr_r    <= 1'b0;
            kbdr_r    <= 16'h0000;
            dsr_r     <= 1'b1;
            ddr_valid <= 1'b0;
            ddr_data  <= 16'h0000;
        end else begin
            if (kb_accept_s) begin
                kbsr_r <= 1'b1;
                kbdr_r <= kb_data;
            end else if (kbdr_clear_s) begin
                kbsr_r <= 1'b0;
            end
            if (ddr_xfer_s) begin
                ddr_valid <= 1'b0;
                dsr_r     <= 1'b1;
            end else if (ddr_load_s) begin
                ddr_valid <= 1'b1;
                ddr_data  <= wdata_r;
                dsr_r     <= 1'b0;
            end
        end
    end

    assign kb_ready = !kbsr_r;

endmodule

// File: tb/tb_lc3_memory.sv
// Scoreboard bench for lc3_memory: a WAIT_STATES=2 instance with devices and a
// WAIT_STATES=0 instance for back-to-back timing, checked against a memory model.
module tb_lc3_memory;

    localparam int WS = 2;
    localparam int AB = 10;
    localparam logic [15:0] MASK = 16'h03FF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mio_en = 1'b0, use0 = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] mar = 16'h0, mdr_in = 16'h0;
    logic        kb_valid = 1'b0, ddr_ready = 1'b0;
    logic [15:0] kb_data = 16'h0;
    logic        r_a, r_b, kb_ready, ddr_valid, kb_ready_b, ddr_valid_b;
    logic [15:0] mdr_a, mdr_b, ddr_data, ddr_data_b;
    logic        mio_a, mio_b, r_m;
    logic [15:0] mdr_m;

    assign mio_a = mio_en && !use0;
    assign mio_b = mio_en && use0;
    assign r_m   = use0 ? r_b : r_a;
    assign mdr_m = use0 ? mdr_b : mdr_a;

    lc3_memory #(.WAIT_STATES(WS), .ADDR_BITS(AB)) u_dut (
        .clk(clk), .reset(reset), .mio_en(mio_a), .r_w(r_w), .mar(mar), .mdr_in(mdr_in),
        .r(r_a), .mdr_out(mdr_a), .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .ddr_valid(ddr_valid), .ddr_data(ddr_data), .ddr_ready(ddr_ready)
    );

    lc3_memory #(.WAIT_STATES(0), .ADDR_BITS(AB)) u_dut0 (
        .clk(clk), .reset(reset), .mio_en(mio_b), .r_w(r_w), .mar(mar), .mdr_in(mdr_in),
        .r(r_b), .mdr_out(mdr_b), .kb_valid(1'b0), .kb_data(16'h0000), .kb_ready(kb_ready_b),
        .ddr_valid(ddr_valid_b), .ddr_data(ddr_data_b), .ddr_ready(1'b1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference model: RAM words per instance, keyboard/display state for u_dut.
    logic [15:0] mem_m [2][1024];
    logic [15:0] last_rd [2];
    logic        kbsr_m = 1'b0, dsr_m = 1'b1, ddrv_m = 1'b0;
    logic [15:0] kbdr_m = 16'h0, ddrd_m = 16'h0;
    logic [15:0] wr_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit dev(input logic [15:0] a);
        return a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06;
    endfunction

    task automatic model_reset();
        kbsr_m = 1'b0; kbdr_m = 16'h0; dsr_m = 1'b1; ddrv_m = 1'b0; ddrd_m = 16'h0;
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    endtask

    task automatic model_access(input int k, input bit w, input logic [15:0] a, input logic [15:0] d);
        if (w) begin
            if (a == 16'hFE06) begin
                if (dsr_m) begin ddrd_m = d; ddrv_m = 1'b1; dsr_m = 1'b0; end
            end else if (!dev(a)) begin
                mem_m[k][a & MASK] = d;
            end
        end else begin
            if (a == 16'hFE00)      last_rd[k] = kbsr_m ? 16'h8000 : 16'h0000;
            else if (a == 16'hFE02) begin last_rd[k] = kbdr_m; kbsr_m = 1'b0; end
            else if (a == 16'hFE04) last_rd[k] = dsr_m ? 16'h8000 : 16'h0000;
            else if (a == 16'hFE06) last_rd[k] = 16'h0000;
            else                    last_rd[k] = mem_m[k][a & MASK];
        end
    endtask

    // Issue one request at a falling edge; returns in the r cycle with mio_en still high.
    task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        int   k = use0 ? 1 : 0;
        int   n = 0;
        r_w = w; mar = a; mdr_in = d; mio_en = 1'b1;
        model_access(k, w, a, d);
        e.due  = cyc + 2 + (use0 ? 0 : WS);
        e.data = last_rd[k];
        sb.push_back(e);
        do begin
            @(negedge clk);
            n++;
        end while (!r_m && n < 40);
        if (!r_m) begin
            total++; bad++;
            $display("FAIL r_timeout: no r after %0d cycles, addr %h", n, a);
            sb.delete();
        end
    endtask

    task automatic idle(input int n);
        mio_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_status();
        check("kb_ready", {15'd0, kb_ready}, {15'd0, !kbsr_m});
        check("ddr_valid", {15'd0, ddr_valid}, {15'd0, ddrv_m});
        check("ddr_data", ddr_data, ddrd_m);
    endtask

    task automatic kb_offer(input logic [15:0] d);
        mio_en = 1'b0; kb_valid = 1'b1; kb_data = d;
        @(posedge clk);
        if (!kbsr_m) begin kbsr_m = 1'b1; kbdr_m = d; end
        @(negedge clk);
        kb_valid = 1'b0;
    endtask

    task automatic ddr_take();
        mio_en = 1'b0; ddr_ready = 1'b1;
        @(posedge clk);
        if (ddrv_m) begin ddrv_m = 1'b0; dsr_m = 1'b1; end
        @(negedge clk);
        ddr_ready = 1'b0;
    endtask

    // Request that is withdrawn (or hit by reset) after 'edges' rising edges.
    task automatic abort_req(input bit w, input logic [15:0] a, input logic [15:0] d,
                             input int edges, input bit rst);
        r_w = w; mar = a; mdr_in = d; mio_en = 1'b1;
        repeat (edges) @(negedge clk);
        if (rst) begin
            reset = 1'b0;
            #1;
            check("rst_ddr_valid", {15'd0, ddr_valid}, 16'h0000);
            check("rst_ddr_data", ddr_data, 16'h0000);
            check("rst_r", {15'd0, r_a}, 16'h0000);
            check("rst_mdr_out", mdr_a, 16'h0000);
            check("rst_kb_ready", {15'd0, kb_ready}, 16'h0001);
            model_reset();
            sb.delete();
            mio_en = 1'b0;
            @(negedge clk);
            reset = 1'b1;
        end else begin
            mio_en = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    // Monitor: every r pulse must match the oldest outstanding expectation.
    logic prev_r = 1'b0;
    always @(negedge clk) begin
        if (r_m) begin
            if (prev_r) check("r_pulse_width", {15'd0, prev_r}, 16'h0000);
            if (sb.size() == 0) begin
                check("unexpected_r", {15'd0, r_m}, 16'h0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_int("r_cycle", cyc, e.due);
                check("mdr_out", mdr_m, e.data);
            end
        end
        prev_r = r_m;
    end

    initial begin
        logic [15:0] a, d, w;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_r", {15'd0, r_a}, 16'h0000);
        check("reset_r0", {15'd0, r_b}, 16'h0000);
        check("reset_mdr_out", mdr_a, 16'h0000);
        check_status();
        reset = 1'b1;
        @(negedge clk);

        // Basic write/read with two wait states.
        access(1'b1, 16'h0010, 16'h1234); idle(2);
        access(1'b0, 16'h0010, 16'h0000); idle(2);
        wr_q.push_back(16'h0010);

        // Keyboard path.
        kb_offer(16'h0041); check_status();
        access(1'b0, 16'hFE00, 16'h0); idle(1);
        kb_offer(16'h0099); check_status();
        access(1'b0, 16'hFE02, 16'h0); idle(1); check_status();
        access(1'b0, 16'hFE00, 16'h0); idle(1);

        // Display path, including a dropped write while busy.
        access(1'b1, 16'hFE06, 16'h0042); idle(1); check_status();
        access(1'b0, 16'hFE04, 16'h0); idle(1);
        access(1'b1, 16'hFE06, 16'h0043); idle(1); check_status();
        ddr_take(); check_status();
        access(1'b0, 16'hFE04, 16'h0); idle(1); check_status();
        access(1'b1, 16'hFE00, 16'hFFFF); idle(1); check_status();

        // Aborts in WAIT and in DONE must leave RAM untouched.
        abort_req(1'b1, 16'h0010, 16'hBEEF, 1, 1'b0);
        access(1'b0, 16'h0010, 16'h0); idle(1);
        abort_req(1'b1, 16'h0010, 16'hBEEF, 3, 1'b0);
        access(1'b0, 16'h0410, 16'h0); idle(1);

        // Back-to-back on the wait-stated instance.
        access(1'b1, 16'h0020, 16'h5A5A);
        access(1'b0, 16'h0020, 16'h0);
        idle(2);
        wr_q.push_back(16'h0020);

        // Zero-wait-state instance, back-to-back.
        use0 = 1'b1;
        access(1'b1, 16'h0000, 16'h1111);
        access(1'b1, 16'h0001, 16'h2222);
        idle(2);
        access(1'b0, 16'h0000, 16'h0);
        access(1'b0, 16'h0001, 16'h0);
        idle(2);
        use0 = 1'b0;

        // Randomized mix against the model.
        repeat (120) begin
            case ($urandom_range(0, 7))
                0, 1: begin
                    a = 16'($urandom);
                    if (dev(a)) a = 16'h0100;
                    d = 16'($urandom);
                    access(1'b1, a, d);
                    wr_q.push_back(a);
                end
                2, 3: begin
                    w = wr_q[$urandom_range(0, wr_q.size() - 1)];
                    a = (16'($urandom) & ~MASK) | (w & MASK);
                    if (dev(a)) a = w;
                    access(1'b0, a, 16'h0);
                end
                4: access(1'b0, 16'hFE00 + 16'($urandom_range(0, 3) * 2), 16'h0);
                5: access(1'b1, 16'hFE00 + 16'($urandom_range(0, 3) * 2), 16'($urandom));
                6: kb_offer(16'($urandom));
                7: ddr_take();
                default: idle(1);
            endcase
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            check_status();
        end
        idle(2);

        // Reset in the middle of a DDR write while the display is busy.
        ddr_take();
        access(1'b1, 16'hFE06, 16'h0055); idle(1); check_status();
        abort_req(1'b1, 16'hFE06, 16'h0066, 1, 1'b1);
        check_status();
        access(1'b0, 16'hFE04, 16'h0); idle(1);
        access(1'b0, 16'h0010, 16'h0); idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
